// File: rtl/ch_seq_pkg.sv
// Shared types for the ch_unit playback sequencer: FSM state, LOAD sub-phase and default widths.
package ch_seq_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int ADDR_W_DEF = 20;
  localparam int REP_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    REARM
  } seq_state_t;

  // Each masked channel takes one address-setup cycle followed by one strobe cycle.
  typedef enum logic {
    LD_ADDR,
    LD_STRB
  } load_ph_t;

endpackage

// File: rtl/ch_done_sync.sv
// Two-flop synchronizer for the per-channel playback_done bits.
// Latency 2 cycles; no backpressure.
module ch_done_sync #(
  parameter int N = 8
) (
  input  logic         s_axi_clk,
  input  logic         s_axi_reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] meta;

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/ch_seq_ctrl.sv
// Playback sequencer: loads one stop address into each masked channel, starts them together, and counts plays.
// Outputs are decoded from registered state; cmd_ready is high only in IDLE; CH_SEQ_WATCHDOG_EN adds a per-play timeout (err_timeout).
module ch_seq_ctrl
  import ch_seq_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int REP_W     = REP_W_DEF,
  parameter int REARM_GAP = 4
`ifdef CH_SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic              s_axi_clk,
  input  logic              s_axi_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N_CH-1:0]   cmd_ch_mask,
  input  logic [ADDR_W-1:0] cmd_stop_addr,
  input  logic [REP_W-1:0]  cmd_repeat,
  input  logic              cmd_abort,
  output logic [ADDR_W-1:0] ch_stop_addr,
  output logic [N_CH-1:0]   ch_write_stop_addr,
  output logic [N_CH-1:0]   ch_playback_en,
  input  logic [N_CH-1:0]   ch_playback_done,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_aborted,
`ifdef CH_SEQ_WATCHDOG_EN
  output logic              err_timeout,
`endif
  output logic [REP_W:0]    play_count
);

  localparam int               GAP_W    = $clog2(REARM_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REARM_GAP - 1);
  localparam logic [REP_W:0]   CNT_MAX  = {1'b1, {REP_W{1'b0}}};

  seq_state_t        state_q, state_d;
  load_ph_t          ph_q, ph_d;
  logic [N_CH-1:0]   mask_q, mask_d, pend_q, pend_d;
  logic [N_CH-1:0]   lsb, done_s, done_m;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [REP_W:0]    cnt_q, cnt_d, cnt_inc, plays_req;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_pls, abort_pls;

`ifdef CH_SEQ_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_d;
`endif

  ch_done_sync #(.N(N_CH)) u_done_sync (
    .s_axi_clk   (s_axi_clk),
    .s_axi_reset (s_axi_reset),
    .din         (ch_playback_done),
    .dout        (done_s)
  );

  assign done_m     = done_s & mask_q;
  assign lsb        = pend_q & (~pend_q + N_CH'(1));
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (REP_W + 1)'(1);
  assign plays_req  = {1'b0, rep_q} + (REP_W + 1)'(1);
  assign play_count = cnt_q;

  always_comb begin
    state_d            = state_q;
    ph_d               = ph_q;
    mask_d             = mask_q;
    pend_d             = pend_q;
    addr_d             = addr_q;
    rep_d              = rep_q;
    cnt_d              = cnt_q;
    gap_d              = gap_q;
    done_pls           = 1'b0;
    abort_pls          = 1'b0;
    cmd_ready          = (state_q == IDLE) && !cmd_abort;
    busy               = (state_q != IDLE);
    ch_stop_addr       = '0;
    ch_write_stop_addr = '0;
    ch_playback_en     = '0;
`ifdef CH_SEQ_WATCHDOG_EN
    wd_d  = (state_q == RUN) ? wd_q + WD_W'(1) : '0;
    err_d = err_timeout;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          mask_d  = cmd_ch_mask;
          pend_d  = cmd_ch_mask;
          addr_d  = cmd_stop_addr;
          rep_d   = cmd_repeat;
          cnt_d   = '0;
          ph_d    = LD_ADDR;
          state_d = LOAD;
`ifdef CH_SEQ_WATCHDOG_EN
          err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        // Only an empty mask reaches LOAD with nothing pending.
        if (pend_q == '0) begin
          done_pls = 1'b1;
          state_d  = IDLE;
        end else begin
          ch_stop_addr = addr_q;
          if (ph_q == LD_ADDR) begin
            ph_d = LD_STRB;
          end else begin
            ch_write_stop_addr = lsb;
            pend_d             = pend_q & ~lsb;
            ph_d               = LD_ADDR;
            if ((pend_q & ~lsb) == '0) state_d = ARM;
          end
        end
      end
      ARM: begin
        if (done_m == '0) state_d = RUN;
      end
      RUN: begin
        ch_playback_en = mask_q;
        if (done_m == mask_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == plays_req) begin
            done_pls = 1'b1;
            state_d  = IDLE;
          end else begin
            gap_d   = '0;
            state_d = REARM;
          end
        end
`ifdef CH_SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          abort_pls = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      REARM: begin
        if (gap_q != GAP_LAST) gap_d = gap_q + GAP_W'(1);
        else if (done_m == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over a completion or timeout seen in the same cycle.
    if (cmd_abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      abort_pls = 1'b1;
      done_pls  = 1'b0;
      cnt_d     = cnt_q;
`ifdef CH_SEQ_WATCHDOG_EN
      err_d = err_timeout;
`endif
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      state_q     <= IDLE;
      ph_q        <= LD_ADDR;
      mask_q      <= '0;
      pend_q      <= '0;
      addr_q      <= '0;
      rep_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      seq_done    <= done_pls;
      seq_aborted <= abort_pls;
    end
  end

`ifdef CH_SEQ_WATCHDOG_EN
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      wd_q        <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      err_timeout <= err_d;
    end
  end
`endif

endmodule

// File: doc/ch_seq_ctrl.md
Name: ch_seq_ctrl

Overview:
- Playback sequencer for a bank of N_CH ch_unit channel instances, in the PL next to the PS GPIO/AXI control.
- Accepts one command from the PS: channel mask, stop address and repeat count.
- Serially loads the stop address into each masked channel, starts all masked channels in the same cycle, and counts completed plays.
- Replaces per-channel software bit-banging of the write_stop_addr, playback_en and playback_done signals.

Parameters:
- N_CH, 8, number of ch_unit channels controlled
- ADDR_W, 20, stop-address width (matches ch_unit RAM address)
- REP_W, 8, repeat-count width
- REARM_GAP, 4, minimum s_axi_clk cycles playback_en is held low between plays
- TIMEOUT_CYC, 2**24, watchdog limit in cycles per play (used only with CH_SEQ_WATCHDOG_EN)

Ports:
- s_axi_clk  in  1  sole clock
- s_axi_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE with cmd_abort low
- cmd_ch_mask  in  N_CH  channels to play
- cmd_stop_addr  in  ADDR_W  stop address for all masked channels
- cmd_repeat  in  REP_W  number of plays = cmd_repeat+1
- cmd_abort  in  1  level; stops the sequence
- ch_stop_addr  out  ADDR_W  shared stop-address bus to all channels
- ch_write_stop_addr  out  N_CH  one-hot 1-cycle strobe
- ch_playback_en  out  N_CH  per-channel enable
- ch_playback_done  in  N_CH  raw done from channels (asynchronous to s_axi_clk)
- busy  out  1  state != IDLE
- seq_done  out  1  1-cycle pulse on normal completion
- seq_aborted  out  1  1-cycle pulse on abort (and on timeout)
- play_count  out  REP_W+1  plays completed in the current or last sequence

Behaviour:
- Reset: all outputs 0 except cmd_ready=1 from the first cycle after reset; state IDLE; counters 0. Reset mid-sequence drops ch_playback_en on the next edge.
- ch_playback_done passes through a 2-flop synchronizer (done_s); this adds 2 cycles of latency.
- IDLE:
  - Accept on cmd_valid & cmd_ready; latch mask, address and repeat; clear play_count; go to LOAD at T+1.
  - cmd_ready is 0 in all other states; cmd_valid there is ignored.
- LOAD:
  - Walk the latched mask from the lowest bit to the highest, 2 cycles per masked bit.
  - Cycle a: ch_stop_addr = latched addr.
  - Cycle b: ch_write_stop_addr[i]=1, address held.
  - Unmasked bits take 0 cycles.
  - After the last masked bit, go to ARM.
  - mask==0: no strobes; seq_done pulses at T+2; return to IDLE.
- ARM: wait until (done_s & mask)==0, then go to RUN. ch_playback_en = mask in the first RUN cycle, so all masked bits rise in the same cycle.
- RUN:
  - When (done_s & mask)==mask, play_count increments.
  - If new count == repeat+1: en=0, seq_done pulse, go to IDLE (the same edge).
  - Otherwise go to REARM with en=0.
  - Done bits outside the mask are ignored. Partial done keeps RUN waiting.
- REARM: hold en=0 for at least REARM_GAP cycles and until (done_s & mask)==0, then go to RUN.
- Abort:
  - cmd_abort high in any non-IDLE state: en=0, strobes=0, seq_aborted pulse, go to IDLE on the next edge. No seq_done is issued.
  - Abort outranks completion in the same cycle.
  - In IDLE, abort forces cmd_ready=0, so no command is accepted.
- play_count saturates at 2**REP_W. It holds after IDLE until the next accept.

Optional Feature:
- Macro: CH_SEQ_WATCHDOG_EN.
- Defined: a cycle counter clears on entering RUN. If it reaches TIMEOUT_CYC before completion, then en=0, seq_aborted pulses, the extra output err_timeout is set sticky (cleared on next accept), and the block goes to IDLE.
- Undefined: no counter and no err_timeout port; RUN waits indefinitely.

Decomposition:
- Package ch_seq_pkg holds:
  - the state encoding (IDLE, LOAD, ARM, RUN, REARM);
  - default widths N_CH/ADDR_W/REP_W;
  - the LOAD sub-phase encoding.
- Sub-module ch_done_sync: N_CH-wide 2-flop synchronizer. It is reset by s_axi_reset to 0.

Test Plan:
- Reset then cmd mask=8'b0000_0101, addr=10, repeat=0:
  - strobes on bit0 then bit2, 2 cycles apart, ch_stop_addr=10;
  - en=0x05 rises in the same cycle;
  - done bits 0 and 2 raised, then seq_done 2 cycles later with play_count=1.
- mask=0x03, repeat=2:
  - three RUN phases;
  - en low for >=4 cycles between plays and until done falls;
  - seq_done after the 3rd done, play_count=3.
- Partial done: only done[0] of mask 0x03 high -> stays in RUN with no count; done[7] outside the mask toggling -> ignored.
- cmd_abort asserted mid-RUN -> en=0 and seq_aborted pulse on the next edge, no seq_done, cmd_ready=1 the following cycle; cmd_valid while busy is never accepted.
- mask=0 -> no strobes, no en, seq_done at T+2.
- With CH_SEQ_WATCHDOG_EN and TIMEOUT_CYC=100 with done held low -> err_timeout=1 and seq_aborted at cycle 100 of RUN.
- s_axi_reset pulsed mid-LOAD -> all outputs 0 next cycle.
